// File: rtl/movement_pkg.sv
// Shared definitions for the object movement scheduler: FSM encoding, screen
// defaults, direction-code field positions and the step-and-wrap helper.
package movement_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_STEP_X = 3'd2;
    localparam logic [2:0] S_STEP_Y = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam int DEF_SCREEN_W = 320;
    localparam int DEF_SCREEN_H = 240;

    localparam int SIGN_X   = 5;
    localparam int MAG_X_HI = 4;
    localparam int MAG_X_LO = 3;
    localparam int SIGN_Y   = 2;
    localparam int MAG_Y_HI = 1;
    localparam int MAG_Y_LO = 0;

    typedef struct packed {
        logic       active;
        logic [5:0] dir;
        logic [8:0] x;
        logic [8:0] y;
    } slot_t;

    // One pixel step with wrap; max_pos is the modulus minus one.
    function automatic logic [8:0] wrap_step(input logic [8:0] pos, input logic neg,
                                             input logic [8:0] max_pos);
        if (neg)
            return (pos == 9'd0) ? max_pos : pos - 9'd1;
        else
            return (pos == max_pos) ? 9'd0 : pos + 9'd1;
    endfunction

endpackage

// File: rtl/move_slot_file.sv
// Object slot register array: one write port, a scheduler read port and an
// asynchronous renderer read port.
module move_slot_file
    import movement_pkg::*;
#(
    parameter  int N_OBJ = 4,
    localparam int IW    = $clog2(N_OBJ)
) (
    input  logic          move_clk,
    input  logic          reset_n,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_slot,
    input  slot_t         wr_data,
    input  logic [IW-1:0] sched_slot,
    output slot_t         sched_data,
    input  logic [IW-1:0] rd_slot,
    output logic          rd_active,
    output logic [8:0]    rd_x,
    output logic [8:0]    rd_y
);

    slot_t slots [N_OBJ];

    always_ff @(posedge move_clk or posedge reset_n) begin
        if (reset_n) begin
            for (int i = 0; i < N_OBJ; i++) slots[i] <= '0;
        end else if (wr_en) begin
            slots[wr_slot] <= wr_data;
        end
    end

    assign sched_data = slots[sched_slot];
    assign rd_active  = slots[rd_slot].active;
    assign rd_x       = slots[rd_slot].x;
    assign rd_y       = slots[rd_slot].y;

endmodule

// File: rtl/object_move_scheduler.sv
// Sweeps all object slots on start, stepping each active object one pixel per
// cycle with screen wrap; committed positions change only in WRITE.
module object_move_scheduler
    import movement_pkg::*;
#(
    parameter  int N_OBJ    = 4,
    parameter  int SCREEN_W = DEF_SCREEN_W,
    parameter  int SCREEN_H = DEF_SCREEN_H,
    localparam int IW       = $clog2(N_OBJ)
) (
    input  logic          move_clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [IW-1:0] ld_slot,
    input  logic          ld_active,
    input  logic [5:0]    ld_dir,
    input  logic [8:0]    ld_x,
    input  logic [8:0]    ld_y,
    input  logic [IW-1:0] rd_slot,
    output logic [8:0]    rd_x,
    output logic [8:0]    rd_y,
    output logic          rd_active,
    output logic          busy,
    output logic          done
);

    localparam logic [8:0] X_MAX = 9'(SCREEN_W - 1);
    localparam logic [8:0] Y_MAX = 9'(SCREEN_H - 1);

    logic [2:0]    state, next_state;
    logic [IW-1:0] idx;
    logic [8:0]    wx, wy;
    logic [1:0]    cx, cy;
    logic [5:0]    wdir;
    slot_t         cur, wr_data;
    logic          wr_en;
    logic [IW-1:0] wr_slot;
    logic          last;
    logic [8:0]    ld_x_clamped, ld_y_clamped;

    assign last         = (idx == IW'(N_OBJ - 1));
    assign ld_x_clamped = (ld_x > X_MAX) ? X_MAX : ld_x;
    assign ld_y_clamped = (ld_y > Y_MAX) ? Y_MAX : ld_y;

    move_slot_file #(.N_OBJ(N_OBJ)) u_slots (
        .move_clk  (move_clk),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_slot   (wr_slot),
        .wr_data   (wr_data),
        .sched_slot(idx),
        .sched_data(cur),
        .rd_slot   (rd_slot),
        .rd_active (rd_active),
        .rd_x      (rd_x),
        .rd_y      (rd_y)
    );

    always_ff @(posedge move_clk or posedge reset_n) begin
        if (reset_n) state <= S_IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (start) next_state = S_FETCH;
            S_FETCH: begin
                if (!cur.active)                            next_state = last ? S_DONE : S_FETCH;
                else if (cur.dir[MAG_X_HI:MAG_X_LO] != 2'd0) next_state = S_STEP_X;
                else if (cur.dir[MAG_Y_HI:MAG_Y_LO] != 2'd0) next_state = S_STEP_Y;
                else                                        next_state = S_WRITE;
            end
            S_STEP_X: begin
                if (cx != 2'd1)      next_state = S_STEP_X;
                else if (cy != 2'd0) next_state = S_STEP_Y;
                else                 next_state = S_WRITE;
            end
            S_STEP_Y: next_state = (cy != 2'd1) ? S_STEP_Y : S_WRITE;
            S_WRITE:  next_state = last ? S_DONE : S_FETCH;
            S_DONE:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // Load and commit share the write port; load is only possible in IDLE.
    always_comb begin
        busy     = (state != S_IDLE);
        ld_ready = (state == S_IDLE);
        done     = (state == S_DONE);
        wr_en    = 1'b0;
        wr_slot  = ld_slot;
        wr_data  = '{active: ld_active, dir: ld_dir, x: ld_x_clamped, y: ld_y_clamped};
        if (state == S_IDLE) begin
            wr_en = ld_valid;
        end else if (state == S_WRITE) begin
            wr_en   = 1'b1;
            wr_slot = idx;
            wr_data = '{active: 1'b1, dir: wdir, x: wx, y: wy};
        end
    end

    always_ff @(posedge move_clk or posedge reset_n) begin
        if (reset_n) begin
            idx  <= '0;
            wx   <= '0;
            wy   <= '0;
            cx   <= '0;
            cy   <= '0;
            wdir <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) idx <= '0;
                S_FETCH: begin
                    wx   <= cur.x;
                    wy   <= cur.y;
                    wdir <= cur.dir;
                    cx   <= cur.dir[MAG_X_HI:MAG_X_LO];
                    cy   <= cur.dir[MAG_Y_HI:MAG_Y_LO];
                    if (!cur.active && !last) idx <= idx + 1'b1;
                end
                S_STEP_X: begin
                    wx <= wrap_step(wx, wdir[SIGN_X], X_MAX);
                    cx <= cx - 2'd1;
                end
                S_STEP_Y: begin
                    wy <= wrap_step(wy, wdir[SIGN_Y], Y_MAX);
                    cy <= cy - 2'd1;
                end
                S_WRITE: if (!last) idx <= idx + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/object_move_scheduler.md
# object_move_scheduler

Time-multiplexes one step-and-wrap movement engine across `N_OBJ` object slots. Each slot holds an active flag, a 6-bit direction code and a 9-bit X/Y position. On each `start` pulse the block sweeps all slots in index order and applies each active object's per-frame displacement, one pixel per cycle, wrapping at the screen edges. It sits between game logic, which writes slots, and the renderer, which reads positions.

## Interface
- `N_OBJ`, 4: number of object slots, 2..16.
- `SCREEN_W`, 320: X wrap modulus; X positions are 0..SCREEN_W-1.
- `SCREEN_H`, 240: Y wrap modulus; Y positions are 0..SCREEN_H-1.
- `move_clk`  in  1  block clock; all state updates on its rising edge.
- `reset_n`  in  1  reset, asynchronous, active-high.
- `start`  in  1  one-cycle request to begin a sweep; ignored unless idle.
- `ld_valid`  in  1  slot write request.
- `ld_ready`  out  1  high only in IDLE; a write occurs when `ld_valid && ld_ready`.
- `ld_slot`  in  clog2(N_OBJ)  slot to write.
- `ld_active`  in  1  new active flag; 0 removes the object.
- `ld_dir`  in  6  direction code: [5] sign_x (1 = −), [4:3] \|dx\|, [2] sign_y (1 = −), [1:0] \|dy\|.
- `ld_x`, `ld_y`  in  9 each  new position.
- `rd_slot`  in  clog2(N_OBJ)  renderer read address.
- `rd_x`, `rd_y`  out  9 each  committed position of `rd_slot`, combinational.
- `rd_active`  out  1  active flag of `rd_slot`, combinational.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at the end of a sweep.

## Operation
- State machine states: IDLE, FETCH, STEP_X, STEP_Y, WRITE, DONE.
- IDLE:
  - A write handshake updates the slot's flag, direction and position.
  - Out-of-range `ld_x`/`ld_y` are clamped to SCREEN_W-1/SCREEN_H-1.
  - `start` sets slot index to 0 and goes to FETCH.
  - `start` and a write in the same cycle are both accepted; the sweep sees the new data.
- FETCH:
  - Copies the slot into working registers wx, wy and counters cx = \|dx\|, cy = \|dy\|.
  - Inactive slot: next slot in FETCH, or DONE if it is the last slot.
  - Active slot: goes to STEP_X if cx≠0, else STEP_Y if cy≠0, else WRITE.
- STEP_X:
  - wx ± 1 with wrap, cx − 1.
  - Stays while the decremented cx≠0; then goes to STEP_Y if cy≠0, else WRITE.
- STEP_Y: wy ± 1 with wrap, cy − 1; stays while the decremented cy≠0; then goes to WRITE.
- WRITE: commits wx/wy to the slot; next slot in FETCH, or DONE after slot N_OBJ-1.
- DONE: `done`=1 for one cycle, then IDLE.
- Wrap rules:
  - X: +1 from SCREEN_W-1 gives 0; −1 from 0 gives SCREEN_W-1.
  - Y: same rule with SCREEN_H.
- A magnitude of 0 with sign 1 means no movement in that axis.
- Committed positions change only in WRITE, so the renderer never sees a half-applied move.

## Timing
- Reset (immediate, including mid-sweep):
  - State IDLE, all slots inactive with dir 0 and position (0,0).
  - `busy`=0, `done`=0, `ld_ready`=1; the working registers are cleared.
- Cycles per slot: inactive = 1; active = 2 + \|dx\| + \|dy\|, so 2..8.
- Total sweep = sum over slots + 1 (DONE). `start`→`busy` high is 1 edge.
- `done` is asserted in the cycle after the last slot's WRITE or FETCH. `busy` falls together with the `done` pulse ending.
- `start` while busy is dropped; it is not queued.
- `ld_valid` while busy is stalled by `ld_ready`=0; the requester holds its inputs.

## Structure
- `movement_pkg` holds:
  - The state encoding localparams.
  - Default SCREEN_W/SCREEN_H.
  - The direction field bit positions (SIGN_X=5, MAG_X=4:3, SIGN_Y=2, MAG_Y=1:0).
- Sub-module `move_slot_file` is the slot register array:
  - One write port shared by load and WRITE, with load possible only in IDLE, so there is no conflict.
  - One scheduler read port and one async renderer read port.
  - Async reset.
- The top level holds the FSM, the working registers and the wrap adders.

## Test plan
- Reset, then read all slots → rd_active=0, (0,0). `busy`=0, `ld_ready`=1.
- Load slot0 with dir 6'b0_10_1_01 at (10,20), others inactive, then `start` → slot0 = (12,19). `done` comes 5+1+1+1+1 = 9 cycles after `start`.
- Load slot1 with dir 6'b1_11_0_00 at (1,5), then sweep → X wraps to (318,5). Load dir 6'b0_00_0_11 at (0,238), then sweep → (0,1).
- Assert `start` mid-sweep and `ld_valid` while busy → no restart, `ld_ready`=0, the slot is unchanged until IDLE, and then the write lands.
- Assert `start` and load in the same IDLE cycle on slot2 → the sweep uses the newly loaded values.
- Assert reset during STEP_X → immediately IDLE, all slots cleared, no `done` pulse.
